// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: receives a 16-bit big-endian word count N
// followed by N big-endian 32-bit words over a byte stream, writes them to
// instruction memory, and holds the CPU in reset while the load runs.
module inst_mem_loader #(
    parameter int Inst_Num     = 150,
    parameter int Inst_Num_BIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    wr_en,
    output logic [Inst_Num_BIT-1:0] wr_addr,
    output logic [31:0]             wr_data,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [Inst_Num_BIT-1:0] word_count
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE} state_t;

    localparam logic [15:0] MAX_LEN = 16'(Inst_Num);

    state_t      state, state_nxt;
    logic [15:0] len;          // requested word count N
    logic [1:0]  byte_idx;     // byte position within the word being assembled
    logic [23:0] word_sr;      // first three bytes of the current word, MSB first
    logic        accept;
    logic [15:0] len_full;     // N as it will be once the low byte lands
    logic [15:0] next_count;   // word_count after the current write

    assign accept     = rx_valid & rx_ready;
    assign len_full   = {len[15:8], rx_data};
    assign next_count = 16'(word_count) + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = LEN_HI;
            LEN_HI: if (accept) state_nxt = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)        state_nxt = DONE;
                    else if (len_full > MAX_LEN)  state_nxt = IDLE;
                    else                          state_nxt = DATA;
                end
            end
            DATA:   if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE:  state_nxt = (next_count == len) ? DONE : DATA;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        rx_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:   ;
            LEN_HI: begin rx_ready = 1'b1; busy = 1'b1; end
            LEN_LO: begin rx_ready = 1'b1; busy = 1'b1; end
            DATA:   begin rx_ready = 1'b1; busy = 1'b1; end
            WRITE:  begin wr_en    = 1'b1; busy = 1'b1; end
            DONE:   begin done     = 1'b1; busy = 1'b1; end
            default: ;
        endcase
        cpu_hold = busy;
    end

    // Datapath: length capture, word assembly, write registers and status.
    // wr_addr/wr_data are loaded on the fourth-byte edge so they are valid
    // for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            len        <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        word_count <= '0;
                    end
                end
                LEN_HI: if (accept) len[15:8] <= rx_data;
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= rx_data;
                        byte_idx <= '0;
                        if (len_full > MAX_LEN) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (byte_idx == 2'd3) begin
                            wr_data <= {word_sr, rx_data};
                            wr_addr <= word_count;
                        end else begin
                            word_sr <= {word_sr[15:0], rx_data};
                        end
                        // wraps to 0 after the fourth byte, ready for the next word
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: word_count <= word_count + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
